// File: rtl/z80_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : z80_timer                                                    |
// | Description : IO-mapped 16-bit down-counting timer slave for the Z80 bus,  |
// |               with prescaler, one-shot/auto-reload expiry and interrupt.   |
// |               Option macro Z80_TIMER_READ_WAIT_EN adds a 1-clk read wait.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package z80_bus_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        rdn;
        logic        wrn;
    } Z80MasterBus;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;
endpackage

module z80_timer
    import z80_bus_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  Z80MasterBus ibus,
    output Z80SlaveBus  obus,
    output logic        int_n
);

    localparam int                     c_presc_w    = $clog2(PRESCALE) + 1;
    localparam logic [c_presc_w-1:0]   c_presc_max  = c_presc_w'(PRESCALE - 1);
    localparam logic [1:0]             c_reg_ctrl   = 2'd0;
    localparam logic [1:0]             c_reg_status = 2'd1;
    localparam logic [1:0]             c_reg_lo     = 2'd2;
    localparam logic [1:0]             c_reg_hi     = 2'd3;

    logic [2:0]           r_ctrl;
    logic                 r_expired;
    logic [15:0]          r_count;
    logic [7:0]           r_reload_lo;
    logic [7:0]           r_reload_hi;
    logic [7:0]           r_hi_latch;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_wr_prev;
    logic                 r_rd_prev;
    logic                 r_int_n;

    logic       w_wr_act, w_rd_act, w_wr_stb, w_rd_stb;
    logic       w_wr_ctrl, w_wr_status, w_wr_lo, w_wr_hi;
    logic       w_stop_wr, w_tick, w_tick_eff, w_cnt_zero, w_expire;
    logic [7:0] w_rd_mux;
    logic [7:0] w_dslave;
    logic       w_mwait;
    logic       w_unused_addr;

    assign w_unused_addr = &{1'b0, ibus.addr[15:2]};

    assign w_wr_act    = ena & ~ibus.wrn;
    assign w_rd_act    = ena & ~ibus.rdn;
    assign w_wr_stb    = w_wr_act & ~r_wr_prev;
    assign w_rd_stb    = w_rd_act & ~r_rd_prev;

    assign w_wr_ctrl   = w_wr_stb & (ibus.addr[1:0] == c_reg_ctrl);
    assign w_wr_status = w_wr_stb & (ibus.addr[1:0] == c_reg_status);
    assign w_wr_lo     = w_wr_stb & (ibus.addr[1:0] == c_reg_lo);
    assign w_wr_hi     = w_wr_stb & (ibus.addr[1:0] == c_reg_hi);

    // A CNT_HI write or a CTRL write that stops the timer swallows a coincident tick.
    assign w_stop_wr   = w_wr_ctrl & ~ibus.dmaster[0];
    assign w_tick      = r_ctrl[0] & (r_presc == c_presc_max);
    assign w_tick_eff  = w_tick & ~w_wr_hi & ~w_stop_wr;
    assign w_cnt_zero  = (r_count == 16'd0);
    assign w_expire    = w_tick_eff & w_cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= 3'd0;
            r_expired   <= 1'b0;
            r_count     <= 16'd0;
            r_reload_lo <= 8'd0;
            r_reload_hi <= 8'd0;
            r_hi_latch  <= 8'd0;
            r_presc     <= '0;
            r_wr_prev   <= 1'b0;
            r_rd_prev   <= 1'b0;
            r_int_n     <= 1'b1;
        end else begin
            r_wr_prev <= w_wr_act;
            r_rd_prev <= w_rd_act;
            r_int_n   <= ~(r_expired & r_ctrl[2]);

            if (w_wr_hi || w_stop_wr || !r_ctrl[0] || (r_presc == c_presc_max))
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;

            if (w_wr_ctrl)
                r_ctrl <= ibus.dmaster[2:0];
            else if (w_expire && !r_ctrl[1])
                r_ctrl[0] <= 1'b0;

            // Expiry takes priority over a simultaneous write-1-to-clear.
            if (w_expire)
                r_expired <= 1'b1;
            else if (w_wr_status && ibus.dmaster[0])
                r_expired <= 1'b0;

            if (w_wr_lo)
                r_reload_lo <= ibus.dmaster;
            if (w_wr_hi)
                r_reload_hi <= ibus.dmaster;

            if (w_wr_hi)
                r_count <= {ibus.dmaster, r_reload_lo};
            else if (w_tick_eff) begin
                if (!w_cnt_zero)
                    r_count <= r_count - 16'd1;
                else if (r_ctrl[1])
                    r_count <= {r_reload_hi, r_reload_lo};
            end

            if (w_rd_stb && (ibus.addr[1:0] == c_reg_lo))
                r_hi_latch <= r_count[15:8];
        end
    end

    always_comb begin
        w_rd_mux = 8'hFF;
        case (ibus.addr[1:0])
            c_reg_ctrl:   w_rd_mux = {5'd0, r_ctrl};
            c_reg_status: w_rd_mux = {7'd0, r_expired};
            c_reg_lo:     w_rd_mux = r_count[7:0];
            default:      w_rd_mux = r_hi_latch;
        endcase
    end

`ifdef Z80_TIMER_READ_WAIT_EN
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= 8'hFF;
        else if (w_rd_stb)
            r_rd_data <= w_rd_mux;
    end

    // The wait cycle covers the capture; afterwards the held snapshot is presented.
    assign w_mwait  = rst | ~w_rd_stb;
    assign w_dslave = (w_rd_act && !rst && !w_rd_stb) ? r_rd_data : 8'hFF;
`else
    assign w_mwait  = 1'b1;
    assign w_dslave = (w_rd_act && !rst) ? w_rd_mux : 8'hFF;
`endif

    always_comb begin
        obus.dslave = w_dslave;
        obus.mwait  = w_mwait;
    end

    assign int_n = r_int_n;

endmodule
`default_nettype wire

// File: tb/tb_z80_timer.sv
`default_nettype none
// Randomized self-checking bench for z80_timer; expected timing comes from
// tick-period arithmetic (expiry every (count+1)*PRESCALE clocks).
module tb_z80_timer;
    import z80_bus_pkg::*;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    Z80MasterBus ibus;
    Z80SlaveBus  obus;
    logic        int_n;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int wr_commit = 0;
    logic mid_int_n;

    z80_timer #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .ibus  (ibus),
        .obus  (obus),
        .int_n (int_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold = 1);
        ibus.addr = {14'd0, a};
        ibus.dmaster = d;
        ibus.wrn = 1'b0;
        ena = 1'b1;
        @(posedge clk);
        #1 wr_commit = cyc;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        mid_int_n = int_n;
        ena = 1'b0;
        ibus.wrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        ibus.addr = {14'd0, a};
        ibus.rdn = 1'b0;
        ena = 1'b1;
        #2;
`ifdef Z80_TIMER_READ_WAIT_EN
        chk("rd_wait_lo", 32'(obus.mwait), 32'd0);
        @(negedge clk);
        chk("rd_wait_hi", 32'(obus.mwait), 32'd1);
        d = obus.dslave;
`else
        chk("rd_mwait", 32'(obus.mwait), 32'd1);
        d = obus.dslave;
        @(negedge clk);
`endif
        ena = 1'b0;
        ibus.rdn = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_fall(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (int_n === 1'b0) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int   t, c, t0, c1, c2, k, nv, r, per, nxt, d;
        logic [15:0] v, w;
        logic [7:0]  lo;

        ibus = '{addr: 16'd0, dmaster: 8'd0, rdn: 1'b1, wrn: 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_int_n", 32'(int_n), 32'd1);
        chk("rst_mwait", 32'(obus.mwait), 32'd1);
        chk("rst_dslave", 32'(obus.dslave), 32'hFF);
        rst = 1'b0;
        @(negedge clk);
        rd_chk("rst_ctrl", 2'd0, 8'h00);
        rd_chk("rst_status", 2'd1, 8'h00);
        rd_chk("rst_lo", 2'd2, 8'h00);
        rd_chk("rst_hi", 2'd3, 8'h00);

        // One-shot, irq disabled: expiry lands exactly 16 clocks after run.
        bus_write(2'd2, 8'h03);
        bus_write(2'd3, 8'h00);
        bus_write(2'd0, 8'h01);
        c = wr_commit;
        wait_to(c + 15);
        rd_chk("os_before", 2'd1, 8'h00);
        rd_chk("os_after", 2'd1, 8'h01);
        rd_chk("os_ctrl", 2'd0, 8'h00);
        rd_chk("os_cnt_lo", 2'd2, 8'h00);
        rd_chk("os_cnt_hi", 2'd3, 8'h00);
        bus_write(2'd1, 8'h01);

        // Randomized one-shot with irq.
        for (int i = 0; i < 4; i++) begin
            nv = $urandom_range(0, 10);
            bus_write(2'd2, 8'(nv));
            bus_write(2'd3, 8'h00);
            bus_write(2'd0, 8'h05);
            c = wr_commit;
            wait_fall((nv + 1) * P + 20, t);
            chk("os_irq_delay", 32'(t - c), 32'((nv + 1) * P + 1));
            rd_chk("os_irq_ctrl", 2'd0, 8'h04);
            rd_chk("os_irq_status", 2'd1, 8'h01);
            rd_chk("os_irq_cnt", 2'd2, 8'h00);
            bus_write(2'd1, 8'h01);
            chk("clr_int_mid", 32'(mid_int_n), 32'd0);
            chk("clr_int_rise", 32'(int_n), 32'd1);
        end

        // Auto-reload: expiries at t0 + k*(R+1)*P; clears land at random phases.
        for (int i = 0; i < 3; i++) begin
            r = $urandom_range(0, 3);
            per = (r + 1) * P;
            bus_write(2'd2, 8'(r));
            bus_write(2'd3, 8'h00);
            bus_write(2'd0, 8'h07);
            t0 = wr_commit;
            wait_fall(per + 20, t);
            chk("ar_first", 32'(t - t0), 32'(per + 1));
            for (int j = 0; j < 4; j++) begin
                d = $urandom_range(0, per + 2);
                repeat (d) @(negedge clk);
                chk("ar_hold", 32'(int_n), 32'd0);
                bus_write(2'd1, 8'h01);
                c = wr_commit;
                if (((c - t0) % per) == 0) begin
                    chk("ar_coll_int", 32'(int_n), 32'd0);
                    rd_chk("ar_coll_status", 2'd1, 8'h01);
                end else begin
                    chk("ar_rise", 32'(int_n), 32'd1);
                    nxt = t0 + ((c - t0) / per + 1) * per;
                    wait_fall(per + 20, t);
                    chk("ar_next", 32'(t), 32'(nxt + 1));
                end
            end
            bus_write(2'd0, 8'h03);
            chk("irqen_off_mid", 32'(mid_int_n), 32'd0);
            chk("irqen_off_rise", 32'(int_n), 32'd1);
            bus_write(2'd0, 8'h04);
            bus_write(2'd1, 8'h01);
        end

        // Coherent 16-bit read; first pass is the 0100 -> 00FF case.
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16'h0100 : 16'($urandom_range(16'h0100, 16'hFFFF));
            d = (i == 0) ? 4 : $urandom_range(0, 40);
            bus_write(2'd2, v[7:0]);
            bus_write(2'd3, v[15:8]);
            rd_chk("coh_lo0", 2'd2, v[7:0]);
            bus_write(2'd0, 8'h01);
            c1 = wr_commit;
            repeat (d) @(negedge clk);
            bus_write(2'd0, 8'h00);
            c2 = wr_commit;
            k = (c2 - c1 - 1) / P;
            w = v - 16'(k);
            rd_chk("coh_hi_latched", 2'd3, v[15:8]);
            rd_chk("coh_lo1", 2'd2, w[7:0]);
            rd_chk("coh_hi1", 2'd3, w[15:8]);
        end

        // Long write strobe: one commit, prescaler restarted once.
        bus_write(2'd2, 8'hFF);
        bus_write(2'd3, 8'hFF);
        bus_write(2'd0, 8'h05);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        nv = $urandom_range(3, 6);
        bus_write(2'd2, 8'(nv));
        bus_write(2'd3, 8'h00, 10);
        c = wr_commit;
        wait_fall((nv + 1) * P + 20, t);
        chk("long_delay", 32'(t - c), 32'((nv + 1) * P + 1));
        rd_chk("long_ctrl", 2'd0, 8'h04);
        lo = 8'($urandom_range(0, 255));
        bus_write(2'd2, lo);
        bus_write(2'd3, 8'h05, 10);
        rd_chk("long_lo", 2'd2, lo);
        rd_chk("long_hi", 2'd3, 8'h05);
        bus_write(2'd1, 8'h01);

        // Stop-write landing on a tick edge swallows that tick.
        bus_write(2'd2, 8'h05);
        bus_write(2'd3, 8'h00);
        bus_write(2'd0, 8'h01);
        c1 = wr_commit;
        wait_to(c1 + 7);
        bus_write(2'd0, 8'h00);
        rd_chk("stop_coll_cnt", 2'd2, 8'h04);

        // STATUS clear landing on an expiry edge loses.
        bus_write(2'd2, 8'h01);
        bus_write(2'd3, 8'h00);
        bus_write(2'd0, 8'h07);
        t0 = wr_commit;
        wait_to(t0 + 15);
        bus_write(2'd1, 8'h01);
        chk("clr_coll_int_mid", 32'(mid_int_n), 32'd0);
        chk("clr_coll_int", 32'(int_n), 32'd0);
        rd_chk("clr_coll_status", 2'd1, 8'h01);

        // Reset asserted for 2 clocks in the middle of a held write.
        chk("pre_rst_int", 32'(int_n), 32'd0);
        ibus.addr = 16'd3;
        ibus.dmaster = 8'h33;
        ibus.wrn = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_int", 32'(int_n), 32'd1);
        chk("mid_rst_mwait", 32'(obus.mwait), 32'd1);
        chk("mid_rst_dslave", 32'(obus.dslave), 32'hFF);
        ena = 1'b0;
        ibus.wrn = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rd_chk("post_rst_ctrl", 2'd0, 8'h00);
        rd_chk("post_rst_status", 2'd1, 8'h00);
        rd_chk("post_rst_lo", 2'd2, 8'h00);
        rd_chk("post_rst_hi", 2'd3, 8'h00);
        repeat (3 * P) @(negedge clk);
        chk("post_rst_int", 32'(int_n), 32'd1);
        rd_chk("post_rst_idle", 2'd1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
